// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, datapath strobe bundle and defaults
// for the radix-4 Booth multiplier controller.
package booth_pkg;
    localparam int NUM_DIGITS_DFLT = 4;
    localparam int CW_DFLT = 2;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef struct packed {
        logic load_a;
        logic load_b;
        logic load_r;
        logic load_c;
        logic clear_a;
        logic clear_b;
        logic clear_r;
        logic clear_c;
        logic shift_a;
        logic cnt_e;
    } ctrl_t;
endpackage

// File: rtl/booth_mult_controller_if.sv
// booth_mult_controller_if: requester/consumer handshakes plus datapath
// strobes and counter feedback between controller and datapath.
interface booth_mult_controller_if #(
    parameter int CW = booth_pkg::CW_DFLT
) ();
    import booth_pkg::*;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic abort;
    logic busy;
    logic [CW-1:0] cnt_out;
    ctrl_t ctrl;
    modport slave (
        input  in_valid, out_ready, abort, cnt_out,
        output in_ready, out_valid, busy, ctrl
    );
    modport master (
        output in_valid, out_ready, abort, cnt_out,
        input  in_ready, out_valid, busy, ctrl
    );
endinterface

// File: rtl/booth_mult_controller.sv
// booth_mult_controller: IDLE/CALC/DONE sequencer for the radix-4 Booth
// datapath; every output is forced low while rst (active-low) is asserted.
module booth_mult_controller
    import booth_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DFLT,
    parameter int CW = CW_DFLT
) (
    input logic clk,
    input logic rst,
    booth_mult_controller_if.slave bus
);
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
    state_t state_q, state_d;
    ctrl_t ctrl;
    logic rdy, vld;
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        ctrl = '0;
        rdy = 1'b0;
        vld = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    ctrl.load_a = 1'b1;
                    ctrl.load_b = 1'b1;
                    ctrl.clear_r = 1'b1;
                    ctrl.clear_c = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // abort suppresses load_r so R never sees load and clear together
                if (bus.abort) begin
                    ctrl.clear_r = 1'b1;
                    state_d = IDLE;
                end else begin
                    ctrl.load_r = 1'b1;
                    ctrl.shift_a = 1'b1;
                    ctrl.cnt_e = 1'b1;
                    state_d = (bus.cnt_out == LAST) ? DONE : CALC;
                end
            end
            DONE: begin
                vld = 1'b1;
                if (bus.abort) begin
                    ctrl.clear_r = 1'b1;
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.ctrl = rst ? ctrl : '0;
    assign bus.in_ready = rst & rdy;
    assign bus.out_valid = rst & vld;
    assign bus.busy = rst & (state_q != IDLE);
endmodule
